// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer
//   Turns the PPU pixel stream into packed framebuffer bytes. Each accepted
//   2-bit colour index is shaded through the BGP palette, four shades are packed
//   per byte (pixel 0 in [7:6]) and the {address, byte} pair is queued in a small
//   write FIFO that feeds a double-buffered framebuffer RAM. At V-blank the
//   queue is drained and the banks are swapped so scan-out only sees whole frames.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   px_in, px_valid  colour index and strobe from the PPU shifter
//   ppu_mode         0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//   lcd_en           LCDC[7]; low clears the writer synchronously
//   bgp              BG palette register
//   fb_addr/fb_data  FIFO head (zero while empty); fb_we = FIFO non-empty
//   fb_ready         RAM accepts the write this cycle
//   fb_bank          bank owned by scan-out; writes target the other bank
//   frame_done       one-cycle pulse on each bank swap
//   overflow         sticky: a packed byte was dropped on a full FIFO
module ppu_fb_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int BANK_SIZE  = 5760
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  px_in,
  input  logic        px_valid,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_en,
  input  logic [7:0]  bgp,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        fb_bank,
  output logic        frame_done,
  output logic        overflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [13:0] BANK_BASE = 14'(BANK_SIZE);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ACTIVE, DRAIN, SWAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    x, y;
  logic [1:0]    pack;
  logic [5:0]    pack_sr;
  logic          line_full;
  logic [1:0]    mode_q;
  logic          overflow_q;
  logic          bank_q;
  logic [21:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          accept, line_end, enter_vblank;
  logic [1:0]    shade;
  logic [13:0]   line_addr, push_addr;
  logic [7:0]    push_data;
  logic          push_full, push_part, push_req, push_ok, pop;
  logic          fifo_empty, fifo_full;
  logic [21:0]   head;

  function automatic logic [1:0] shade_of(input logic [7:0] pal, input logic [1:0] idx);
    return pal[{idx, 1'b0} +: 2];
  endfunction

  // Left-justify the pixels collected so far; unused low slots read as 0.
  function automatic logic [7:0] pad_partial(input logic [5:0] sr, input logic [1:0] n);
    case (n)
      2'd1:    return {sr[1:0], 6'b0};
      2'd2:    return {sr[3:0], 4'b0};
      default: return {sr, 2'b0};
    endcase
  endfunction

  always_comb begin
    accept       = px_valid && (ppu_mode == 2'd3) && lcd_en && !line_full &&
                   (y < 8'd144) && (state == ACTIVE);
    line_end     = lcd_en && (mode_q == 2'd3) && (ppu_mode != 2'd3) && (x != 8'd0);
    enter_vblank = (ppu_mode == 2'd1) && (mode_q != 2'd1);
    shade        = shade_of(bgp, px_in);
    line_addr    = (bank_q ? 14'd0 : BANK_BASE) + 14'(y) * 14'd40;
    // Same expression serves both cases: x is pre-increment for a full byte and
    // still points inside the partial byte at line end.
    push_addr    = line_addr + {8'b0, x[7:2]};
    push_full    = accept && (pack == 2'd3);
    push_part    = line_end && (pack != 2'd0);
    push_req     = push_full || push_part;
    push_data    = push_full ? {pack_sr, shade} : pad_partial(pack_sr, pack);
    fifo_empty   = (count == '0);
    fifo_full    = (count == FULL_CNT);
    pop          = !fifo_empty && fb_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push_ok      = push_req && (!fifo_full || pop);
    head         = mem[rd_ptr];
  end

  // Frame state register and control counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACTIVE;
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      line_full  <= 1'b0;
      mode_q     <= '0;
      overflow_q <= 1'b0;
      bank_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (!lcd_en) begin
      state      <= ACTIVE;
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      line_full  <= 1'b0;
      mode_q     <= ppu_mode;
      overflow_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state  <= state_nxt;
      mode_q <= ppu_mode;
      if (state == SWAP) begin
        x         <= '0;
        y         <= '0;
        pack      <= '0;
        line_full <= 1'b0;
        bank_q    <= ~bank_q;
      end else if (line_end) begin
        x         <= '0;
        y         <= y + 8'd1;
        pack      <= '0;
        line_full <= 1'b0;
      end else if (accept) begin
        x    <= x + 8'd1;
        pack <= pack + 2'd1;
        if (x == 8'd159) line_full <= 1'b1;
      end
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pixel shift register and FIFO storage
  always_ff @(posedge clk) begin
    if (accept) pack_sr <= {pack_sr[3:0], shade};
    if (push_ok && lcd_en) mem[wr_ptr] <= {push_addr, push_data};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (enter_vblank) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !push_req) state_nxt = SWAP;
      SWAP:    state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  always_comb begin
    fb_we      = !fifo_empty;
    fb_addr    = fifo_empty ? 14'd0 : head[21:8];
    fb_data    = fifo_empty ? 8'd0  : head[7:0];
    fb_bank    = bank_q;
    frame_done = (state == SWAP);
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_ppu_fb_writer.sv
module tb_ppu_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic        lcd_en;
  logic [7:0]  bgp;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        fb_bank;
  logic        frame_done;
  logic        overflow;

  ppu_fb_writer #(.FIFO_DEPTH(8), .BANK_SIZE(5760)) dut (
    .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid),
    .ppu_mode(ppu_mode), .lcd_en(lcd_en), .bgp(bgp),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
    .fb_bank(fb_bank), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_frame = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expected {addr,data} on every accepted write and
  // checks the head stays put while the RAM stalls.
  logic        stall_v = 1'b0;
  logic [21:0] stall_word;
  always @(negedge clk) begin
    if (!rst) begin
      stall_v = 1'b0;
    end else begin
      if (frame_done) n_frame++;
      if (stall_v) chk("hold", {10'b0, fb_addr, fb_data}, {10'b0, stall_word});
      if (fb_we && !fb_ready) begin
        stall_v    = 1'b1;
        stall_word = {fb_addr, fb_data};
      end else begin
        stall_v = 1'b0;
      end
      if (fb_we && fb_ready) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data 0x%02h, none expected", fb_addr, fb_data);
        end else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          chk("write", {10'b0, fb_addr, fb_data}, {10'b0, e});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] shade_m(input logic [7:0] b, input int p);
    logic [7:0] t;
    t = b >> (2 * p);
    return t[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input logic [1:0] p);
    px_valid = 1'b1;
    px_in    = p;
    tick();
    px_valid = 1'b0;
  endtask

  task automatic line_end();
    ppu_mode = 2'd0;
    tick();
    ppu_mode = 2'd3;
  endtask

  task automatic lcd_clear();
    lcd_en = 1'b0;
    tick();
    lcd_en = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      tick();
      c++;
    end
    tick();
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Drives n pixels with pattern (i+seed)%4; expects the first `keep` bytes.
  task automatic send_line(input int n, input logic [13:0] base, input int seed,
                           input int keep, input bit do_end);
    logic [7:0] acc;
    int cnt, nb, p;
    acc = 8'd0; cnt = 0; nb = 0;
    for (int i = 0; i < n; i++) begin
      p = (i + seed) % 4;
      if (i < 160) begin
        acc = {acc[5:0], shade_m(bgp, p)};
        cnt++;
        if (cnt == 4) begin
          if (nb < keep) exp_q.push_back({base + 14'(i / 4), acc});
          nb++;
          cnt = 0;
        end
      end
      drive_px(2'(p));
    end
    if (do_end) begin
      if (cnt != 0) begin
        acc = acc << (2 * (4 - cnt));
        if (nb < keep) exp_q.push_back({base + 14'(n / 4), acc});
      end
      line_end();
    end
  endtask

  int wr0, fr0;

  initial begin
    rst = 1'b0; px_in = 2'd0; px_valid = 1'b0; ppu_mode = 2'd3;
    lcd_en = 1'b1; bgp = 8'hE4; fb_ready = 1'b1;
    #1;
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_fb_bank", fb_bank, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single byte: 0,1,2,3 through identity palette -> 0x1B at bank 1 base
    exp_q.push_back({14'd5760, 8'h1B});
    drive_px(2'd0); drive_px(2'd1); drive_px(2'd2); drive_px(2'd3);
    chk("lat_we", fb_we, 1);
    chk("lat_addr", fb_addr, 5760);
    chk("lat_data", fb_data, 8'h1B);
    tick();
    chk("one_cycle_we", fb_we, 0);
    line_end();

    // Palette 0x1B: idx0 -> 3, idx3 -> 0; second line of the frame
    bgp = 8'h1B;
    exp_q.push_back({14'd5800, 8'hF0});
    drive_px(2'd0); drive_px(2'd0); drive_px(2'd3); drive_px(2'd3);
    line_end();
    wait_drain(10);
    bgp = 8'hE4;
    lcd_clear();

    // Short line (146 px, partial last byte), then an overlong line (164 px)
    wr0 = n_wr;
    send_line(146, 14'd5760, 1, 1000, 1'b1);
    wait_drain(10);
    chk("short_line_writes", n_wr - wr0, 37);
    send_line(164, 14'd5800, 2, 1000, 1'b1);
    wait_drain(10);
    chk("long_line_writes", n_wr - wr0, 77);
    lcd_clear();

    // Backpressure: 40 pixels with RAM stalled; only 8 bytes survive
    fb_ready = 1'b0;
    send_line(40, 14'd5760, 3, 8, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("stall_we", fb_we, 1);
    fb_ready = 1'b1;
    wait_drain(20);
    chk("ovf_sticky", overflow, 1);
    line_end();
    lcd_clear();
    chk("ovf_cleared", overflow, 0);

    // Full frame into bank 1 region, then V-blank swap
    wr0 = n_wr; fr0 = n_frame;
    for (int l = 0; l < 144; l++) send_line(160, 14'(5760 + l * 40), l, 1000, 1'b1);
    ppu_mode = 2'd1;
    for (int i = 0; i < 20; i++) tick();
    chk("frame_writes", n_wr - wr0, 5760);
    chk("frame_done_pulses", n_frame - fr0, 1);
    chk("bank_after_swap", fb_bank, 1);
    chk("frame_q_empty", exp_q.size(), 0);
    ppu_mode = 2'd2;
    tick(); tick();
    ppu_mode = 2'd3;
    send_line(160, 14'd0, 5, 1000, 1'b1);
    send_line(160, 14'd40, 6, 1000, 1'b1);
    wait_drain(10);

    // Async reset mid-line with bytes queued
    fb_ready = 1'b0;
    send_line(8, 14'd0, 0, 0, 1'b0);
    chk("pre_rst_we", fb_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", fb_we, 0);
    chk("arst_bank", fb_bank, 0);
    chk("arst_addr", fb_addr, 0);
    chk("arst_data", fb_data, 0);
    tick();
    rst = 1'b1;
    fb_ready = 1'b1;
    tick();
    exp_q.push_back({14'd5760, 8'h1B});
    drive_px(2'd0); drive_px(2'd1); drive_px(2'd2); drive_px(2'd3);
    wait_drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
